// File: rtl/div32_if.sv
// div32_if: operand/result bundle between the multdiv sequencer and div32.
//   ctrl_DIV        start pulse, operands sampled on the same edge
//   dividend        two's-complement numerator
//   divisor         two's-complement denominator
//   data_result     quotient, truncated toward zero
//   data_exception  divide-by-zero or overflow, valid with data_resultRDY
//   data_resultRDY  one-cycle result-valid pulse
interface div32_if;
    logic        ctrl_DIV;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_DIV, dividend, divisor,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_DIV, dividend, divisor,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/div32.sv
// div32: sequential 32-bit signed divider, one quotient bit per cycle
// (restoring division on magnitudes), result 33 cycles after the start pulse.
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    div32_if.slave: start/operands in, quotient/exception/ready out
//
// state  | meaning
// IDLE   | waiting for ctrl_DIV, outputs hold the last result
// RUN    | 32 shift/subtract iterations, counter counts 31 down to 0
// DONE   | result presented, data_resultRDY high for this cycle only
module div32 (
    input  logic    clock,
    input  logic    reset,
    div32_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        sign_q, sign_d;
    logic        divz_q, divz_d;
    logic        ovf_q, ovf_d;

    logic [32:0] r_sh;
    logic [32:0] trial;
    logic [31:0] res_done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        b_d      = b_q;
        res_d    = res_q;
        exc_d    = exc_q;
        sign_d   = sign_q;
        divz_d   = divz_q;
        ovf_d    = ovf_q;

        // The partial remainder is always below |divisor| <= 2^31 after an
        // iteration, so 32 stored bits suffice; the shifted value needs 33.
        r_sh     = {r_q, q_q[31]};
        trial    = r_sh - {1'b0, b_q};
        res_done = divz_q ? 32'd0 : (sign_q ? (~q_q + 32'd1) : q_q);

        case (state_q)
            S_RUN: begin
                r_d   = trial[32] ? r_sh[31:0] : trial[31:0];
                q_d   = {q_q[30:0], ~trial[32]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_d   = res_done;
                exc_d   = divz_q | ovf_q;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // A start wins in every state; in DONE the result registers above
        // still capture the finishing operation.
        if (bus.ctrl_DIV) begin
            q_d     = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
            b_d     = bus.divisor[31]  ? (~bus.divisor + 32'd1)  : bus.divisor;
            sign_d  = bus.dividend[31] ^ bus.divisor[31];
            divz_d  = (bus.divisor == 32'd0);
            ovf_d   = (bus.dividend == 32'h8000_0000) && (bus.divisor == 32'hFFFF_FFFF);
            r_d     = 32'd0;
            cnt_d   = 5'd31;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            r_q     <= 32'd0;
            q_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            sign_q  <= 1'b0;
            divz_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            sign_q  <= sign_d;
            divz_q  <= divz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.data_resultRDY = (state_q == S_DONE);
    assign bus.data_result    = (state_q == S_DONE) ? res_done : res_q;
    assign bus.data_exception = (state_q == S_DONE) ? (divz_q | ovf_q) : exc_q;
endmodule

// File: tb/tb_div32.sv
// tb_div32: directed self-checking bench for div32.
module tb_div32;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div32_if bus ();

    div32 dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Each call leaves the bench 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start sampled on the next edge; that edge ends cycle N.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        step(1);
        bus.ctrl_DIV = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_e);
        start(a, b);
        step(31);
        chk({tag, " rdy@N+32"}, {31'd0, bus.data_resultRDY}, 32'd0);
        step(1);
        chk({tag, " rdy@N+33"}, {31'd0, bus.data_resultRDY}, 32'd1);
        chk({tag, " result"},   bus.data_result, exp_q);
        chk({tag, " exc"},      {31'd0, bus.data_exception}, {31'd0, exp_e});
        step(1);
        chk({tag, " rdy@N+34"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    // Behavioural reference for the randomised pairs.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    int          pulses;
    logic [31:0] ra, rb;
    logic [32:0] m;

    initial begin
        checks = 0;
        errors = 0;
        bus.ctrl_DIV = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("reset rdy",    {31'd0, bus.data_resultRDY}, 32'd0);
        chk("reset result", bus.data_result, 32'd0);
        chk("reset exc",    {31'd0, bus.data_exception}, 32'd0);

        // 100/7 with hold check afterwards
        run_div("100/7", 32'd100, 32'd7, 32'd14, 1'b0);
        step(6);
        chk("hold @N+40", bus.data_result, 32'd14);
        chk("hold rdy",   {31'd0, bus.data_resultRDY}, 32'd0);

        run_div("-100/7",  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
        run_div("100/-7",  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0);
        run_div("7/0",     32'd7,         32'd0,         32'd0,         1'b1);
        run_div("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_div("min/1",   32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_div("5/9",     32'd5,         32'd9,         32'd0,         1'b0);
        run_div("-1/2",    32'hFFFF_FFFF, 32'd2,         32'd0,         1'b0);
        run_div("max/max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1,         1'b0);
        run_div("min/min", 32'h8000_0000, 32'h8000_0000, 32'd1,         1'b0);
        run_div("-7/-1",   32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd7,         1'b0);

        // Restart mid-RUN: 1000/3 at N, 50/5 at N+10
        start(32'd1000, 32'd3);
        step(9);
        start(32'd50, 32'd5);
        pulses = 0;
        repeat (32) begin
            if (bus.data_resultRDY) pulses++;
            step(1);
        end
        chk("restart no early rdy", pulses, 0);
        chk("restart rdy",    {31'd0, bus.data_resultRDY}, 32'd1);
        chk("restart result", bus.data_result, 32'd10);

        // Reset at N+20 of 1000/3
        step(1);
        start(32'd1000, 32'd3);
        step(19);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrun reset result", bus.data_result, 32'd0);
        pulses = 0;
        repeat (40) begin
            if (bus.data_resultRDY) pulses++;
            step(1);
        end
        chk("midrun reset no rdy", pulses, 0);
        chk("midrun reset result late", bus.data_result, 32'd0);
        chk("midrun reset exc", {31'd0, bus.data_exception}, 32'd0);

        // Reset together with a start
        rst = 1'b1;
        bus.ctrl_DIV = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        step(1);
        rst = 1'b0;
        bus.ctrl_DIV = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (bus.data_resultRDY) pulses++;
            step(1);
        end
        chk("reset+start no rdy", pulses, 0);
        chk("reset+start result", bus.data_result, 32'd0);

        // Back-to-back: 81/9 at N, 64/8 at N+33
        start(32'd81, 32'd9);
        step(32);
        chk("b2b first rdy",    {31'd0, bus.data_resultRDY}, 32'd1);
        chk("b2b first result", bus.data_result, 32'd9);
        start(32'd64, 32'd8);
        chk("b2b gap rdy",      {31'd0, bus.data_resultRDY}, 32'd0);
        chk("b2b hold result",  bus.data_result, 32'd9);
        step(31);
        chk("b2b N+65 rdy",     {31'd0, bus.data_resultRDY}, 32'd0);
        step(1);
        chk("b2b second rdy",   {31'd0, bus.data_resultRDY}, 32'd1);
        chk("b2b second result", bus.data_result, 32'd8);
        step(1);
        chk("b2b after rdy",    {31'd0, bus.data_resultRDY}, 32'd0);

        // A few random pairs against the reference
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 6)
                0:       rb = 32'd1;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd0;
                3:       rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            m = model(ra, rb);
            run_div("rand", ra, rb, m[31:0], m[32]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div32.md
# div32

Sequential 32-bit signed integer divider for the processor's multdiv unit, the counterpart of the 32-bit multiplier. It accepts a one-cycle start pulse with dividend and divisor, then runs a one-bit-per-cycle restoring division on magnitudes. It returns a truncated-toward-zero quotient with a ready pulse and an exception flag. The register file and ALU sequencing logic consume its outputs exactly as they consume the multiplier's.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ctrl_DIV`  in  1  start pulse; operands sampled on the same edge.
- `dividend`  in  32  two's-complement numerator.
- `divisor`  in  32  two's-complement denominator.
- `data_result`  out  32  quotient, truncated toward zero.
- `data_exception`  out  1  divide-by-zero or overflow; valid with ready.
- `data_resultRDY`  out  1  one-cycle pulse when the result is valid.

## Operation
- **States:** IDLE, RUN, DONE. 5-bit iteration counter plus one carry state bit, or a 6-bit counter.
- **Start (any state):** `ctrl_DIV`=1 at an edge does the following, then enters RUN:
  - captures |dividend| and |divisor| as 32-bit unsigned values (|0x80000000| = 0x80000000);
  - captures sign = dividend[31] ^ divisor[31];
  - captures divz = (divisor == 0) and ovf = (dividend == 0x80000000 && divisor == 0xFFFFFFFF);
  - clears the 33-bit partial remainder R and the counter.
- **RUN iteration (32 edges):**
  - shift {R, Q} left one bit, bringing the next dividend bit into Q[0];
  - compute trial = R - |divisor| at 33 bits;
  - if trial ≥ 0, set R = trial and Q[0] = 1; otherwise keep R.
  - After the 32nd iteration, go to DONE.
- **DONE (one cycle):**
  - `data_result` = divz ? 0 : (sign ? -Q : Q), 32-bit wrap;
  - ovf gives 0x80000000 via that wrap;
  - `data_exception` = divz | ovf;
  - `data_resultRDY` = 1;
  - next state is IDLE.
- **Holding:** `data_result` and `data_exception` hold their values in IDLE until the next DONE or `reset`. `data_resultRDY` is 0 outside DONE.
- **Remainder:** not exposed. Remainder sign handling is out of scope.
- **Divide-by-zero:** takes the full latency; no early exit.
- **`ctrl_DIV` in RUN:** aborts the current operation and restarts with the new operands. The aborted operation produces no ready pulse.
- **`ctrl_DIV` in DONE:** the ready pulse for the old operation still occurs that cycle, and the new operation starts.
- **Operand stability:** operands need only be valid on the start edge. Internal copies are used afterward.

## Timing
- **Reset:** `reset`=1 at an edge forces IDLE, counter 0, R/Q 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0. `reset` takes priority over a simultaneous `ctrl_DIV`.
- **Latency:** if `ctrl_DIV` is high in cycle N, `data_resultRDY` is high in cycle N+33 only. Outputs change at the edge ending cycle N+32.
- **Throughput:** one division per 33 cycles. A new start may coincide with the DONE cycle, giving back-to-back results every 33 cycles.
- **Reset mid-RUN:** the operation is discarded, no ready pulse occurs, and outputs return to reset values the next cycle.
- **Combinational depth:** at most one 33-bit subtract and a 2:1 mux per cycle. The negations occur only at capture and at DONE.

## Test plan
- **Basic signs:**
  - 100 / 7 in cycle N → cycle N+33: RDY=1, result=14 (0x0000000E), exception=0; RDY=0 in N+32 and N+34, result still 14 in N+40.
  - -100 / 7 → 0xFFFFFFF2 (-14); 100 / -7 → 0xFFFFFFF2; -100 / -7 → 14.
- **Special cases:**
  - 7 / 0 → result=0, exception=1 at N+33.
  - 0x80000000 / 0xFFFFFFFF → result=0x80000000, exception=1.
  - 0x80000000 / 1 → 0x80000000, exception=0.
  - 5 / 9 → 0; 0xFFFFFFFF / 0x00000002 → 0.
- **Restart mid-RUN:** start 1000/3 at N, then 50/5 at N+10 → no RDY at N+33, RDY at N+43 with result=10.
- **Reset:**
  - `reset` at N+20 of 1000/3 → no RDY through N+60, all outputs 0.
  - `reset` and `ctrl_DIV` together → stays IDLE, no RDY.
- **Back-to-back:** start 81/9 at N, then 64/8 at N+33 → RDY at N+33 (9) and N+66 (8), each one cycle wide.
- **Randomised:** 10k random operand pairs, plus divisors ±1 and 0, compared against a behavioural model of `$signed` division with truncation toward zero and the exception rules above.
